// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS-style mult/multu/div/divu: one bit per cycle on magnitudes,
// sign fix-up in a final cycle, 34-cycle op-to-op throughput.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input logic         clk_in,
   input logic         reset,
   mdu_iter_if.slave   bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   // mult: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
   logic [2*WIDTH:0]   acc;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic               signed_op;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   assign signed_op = ~bus.op[0];
   assign abs_a     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign abs_b     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic               rem_ge;
   logic [2*WIDTH:0]   acc_next;

   always_comb begin
      add_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_a} : '0);
      rem_shift = acc[2*WIDTH-1:WIDTH-1];
      rem_diff  = rem_shift - {1'b0, mag_b};
      rem_ge    = rem_shift >= {1'b0, mag_b};
      acc_next  = {1'b0, add_sum, acc[WIDTH-1:1]};
      if (is_div)
         acc_next = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                           : {rem_shift, acc[WIDTH-2:0], 1'b0};
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Divide by zero falls out as remainder=|a|, so only the quotient needs forcing.
   always_comb begin
      prod_fix = (sign_a ^ sign_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
      rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      if (mag_b == '0)
         quo_fix = '1;
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  is_div <= bus.op[1];
                  sign_a <= signed_op & bus.a[WIDTH-1];
                  sign_b <= signed_op & bus.b[WIDTH-1];
                  mag_a  <= abs_a;
                  mag_b  <= abs_b;
                  acc    <= {{(WIDTH+1){1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               if (bus.flush) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH-1))
                     state <= FIX;
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               state  <= IDLE;
               if (!bus.flush) begin
                  hi_q   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                  lo_q   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                  done_q <= 1'b1;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule
